// File: rtl/trueport_ram_if.sv
// trueport_ram_if: both port buses and status flags of the true dual-port RAM
interface trueport_ram_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10
);
    logic                wren_a, rden_a, wren_b, rden_b;
    logic [ADDR_W-1:0]   address_a, address_b;
    logic [DATA_W-1:0]   data_a, data_b, q_a, q_b;
    logic [DATA_W/8-1:0] byteen_a, byteen_b;
    logic                valid_a, err_a, valid_b, err_b, busy, collision;
    modport master (
        output wren_a, rden_a, address_a, data_a, byteen_a,
        output wren_b, rden_b, address_b, data_b, byteen_b,
        input  q_a, valid_a, err_a, q_b, valid_b, err_b, busy, collision
    );
    modport slave (
        input  wren_a, rden_a, address_a, data_a, byteen_a,
        input  wren_b, rden_b, address_b, data_b, byteen_b,
        output q_a, valid_a, err_a, q_b, valid_b, err_b, busy, collision
    );
endinterface

// File: rtl/trueport_ram_ext.sv
// trueport_ram_ext: single-clock true dual-port RAM with byte enables, collision merge and post-reset clear
module trueport_ram_ext #(
    parameter int                DATA_W   = 8,
    parameter int                ADDR_W   = 10,
    parameter int                DEPTH    = 1024,
    parameter int                RDW_MODE = 0,
    parameter int                OUT_REG  = 0,
    parameter logic [DATA_W-1:0] CLR_VAL  = '0
) (
    input logic           clk,
    input logic           rst,
    trueport_ram_if.slave bus
);
    localparam int NB = DATA_W / 8;
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam logic [0:0] CLEAR = 1'b0;
    localparam logic [0:0] IDLE  = 1'b1;
    logic [0:0]        state;
    logic [AW-1:0]     ptr, ia, ib;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              acc, inr_a, inr_b, wr_a, wr_b, wr_b_eff, coll, rd_a, rd_b;
    logic [DATA_W-1:0] old_a, old_b, new_a, new_b, rq_a, rq_b;
    logic              s1_v_a, s1_e_a, s1_v_b, s1_e_b;
    logic [DATA_W-1:0] s1_d_a, s1_d_b;
    logic              p_v_a, p_e_a, p_v_b, p_e_b;
    logic [DATA_W-1:0] p_d_a, p_d_b;
    assign bus.busy = state == CLEAR;
    always_comb begin
        acc      = !rst && state == IDLE;
        ia       = bus.address_a[AW-1:0];
        ib       = bus.address_b[AW-1:0];
        inr_a    = {1'b0, bus.address_a} < (ADDR_W+1)'(DEPTH);
        inr_b    = {1'b0, bus.address_b} < (ADDR_W+1)'(DEPTH);
        wr_a     = acc && bus.wren_a && inr_a;
        wr_b     = acc && bus.wren_b && inr_b;
        rd_a     = acc && bus.rden_a;
        rd_b     = acc && bus.rden_b;
        coll     = wr_a && wr_b && bus.address_a == bus.address_b;
        wr_b_eff = wr_b && !coll;
        old_a    = mem[ia];
        old_b    = mem[ib];
        new_a    = old_a;
        new_b    = old_b;
        // on a collision port A's word absorbs the bytes only B enabled, so one write lands
        for (int i = 0; i < NB; i++) begin
            new_a[8*i+:8] = bus.byteen_a[i] ? bus.data_a[8*i+:8] :
                            (coll && bus.byteen_b[i]) ? bus.data_b[8*i+:8] : old_a[8*i+:8];
            new_b[8*i+:8] = bus.byteen_b[i] ? bus.data_b[8*i+:8] : old_b[8*i+:8];
        end
        rq_a = !inr_a ? '0 : RDW_MODE == 0 ? old_a : wr_a ? new_a :
               (wr_b_eff && bus.address_b == bus.address_a) ? new_b : old_a;
        rq_b = !inr_b ? '0 : RDW_MODE == 0 ? old_b :
               (wr_a && bus.address_a == bus.address_b) ? new_a : wr_b_eff ? new_b : old_b;
        p_v_a = OUT_REG != 0 ? s1_v_a : rd_a;
        p_e_a = OUT_REG != 0 ? s1_e_a : rd_a && !inr_a;
        p_d_a = OUT_REG != 0 ? s1_d_a : rq_a;
        p_v_b = OUT_REG != 0 ? s1_v_b : rd_b;
        p_e_b = OUT_REG != 0 ? s1_e_b : rd_b && !inr_b;
        p_d_b = OUT_REG != 0 ? s1_d_b : rq_b;
    end
    always_ff @(posedge clk) begin
        if (!rst && state == CLEAR) mem[ptr] <= CLR_VAL;
        if (wr_a) mem[ia] <= new_a;
        if (wr_b_eff) mem[ib] <= new_b;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= CLEAR;
            ptr           <= '0;
            s1_v_a        <= 1'b0;
            s1_e_a        <= 1'b0;
            s1_d_a        <= '0;
            s1_v_b        <= 1'b0;
            s1_e_b        <= 1'b0;
            s1_d_b        <= '0;
            bus.q_a       <= '0;
            bus.q_b       <= '0;
            bus.valid_a   <= 1'b0;
            bus.valid_b   <= 1'b0;
            bus.err_a     <= 1'b0;
            bus.err_b     <= 1'b0;
            bus.collision <= 1'b0;
        end else begin
            if (state == CLEAR) begin
                ptr <= ptr + AW'(1);
                if (ptr == AW'(DEPTH - 1)) state <= IDLE;
            end
            s1_v_a        <= rd_a;
            s1_e_a        <= rd_a && !inr_a;
            s1_d_a        <= rq_a;
            s1_v_b        <= rd_b;
            s1_e_b        <= rd_b && !inr_b;
            s1_d_b        <= rq_b;
            bus.valid_a   <= p_v_a;
            bus.valid_b   <= p_v_b;
            bus.err_a     <= p_e_a || (acc && bus.wren_a && !inr_a);
            bus.err_b     <= p_e_b || (acc && bus.wren_b && !inr_b);
            bus.collision <= coll;
            if (p_v_a) bus.q_a <= p_d_a;
            if (p_v_b) bus.q_b <= p_d_b;
        end
    end
endmodule

// File: tb/tb_trueport_ram_ext.sv
// tb_trueport_ram_ext: two RAM configurations driven in lockstep and checked against a word-level model
module tb_trueport_ram_ext;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;
    logic        wr [2], rd [2];
    logic [9:0]  ad [2];
    logic [15:0] dt [2];
    logic [1:0]  be [2];
    logic [15:0] oq [2][2];
    logic        ov [2][2], oe [2][2], ob [2], oc [2];
    trueport_ram_if #(.DATA_W(16), .ADDR_W(10)) bus [2] ();
    for (genvar g = 0; g < 2; g++) begin : g_conn
        assign bus[g].wren_a = wr[0];
        assign bus[g].rden_a = rd[0];
        assign bus[g].address_a = ad[0];
        assign bus[g].data_a = dt[0];
        assign bus[g].byteen_a = be[0];
        assign bus[g].wren_b = wr[1];
        assign bus[g].rden_b = rd[1];
        assign bus[g].address_b = ad[1];
        assign bus[g].data_b = dt[1];
        assign bus[g].byteen_b = be[1];
        assign oq[g][0] = bus[g].q_a;
        assign oq[g][1] = bus[g].q_b;
        assign ov[g][0] = bus[g].valid_a;
        assign ov[g][1] = bus[g].valid_b;
        assign oe[g][0] = bus[g].err_a;
        assign oe[g][1] = bus[g].err_b;
        assign ob[g] = bus[g].busy;
        assign oc[g] = bus[g].collision;
    end
    trueport_ram_ext #(.DATA_W(16), .ADDR_W(10), .DEPTH(1000), .RDW_MODE(1), .OUT_REG(0), .CLR_VAL(16'hA5C3))
        dut0 (.clk(clk), .rst(rst), .bus(bus[0]));
    trueport_ram_ext #(.DATA_W(16), .ADDR_W(10), .DEPTH(512), .RDW_MODE(0), .OUT_REG(1), .CLR_VAL(16'h0000))
        dut1 (.clk(clk), .rst(rst), .bus(bus[1]));
    int          dep [2] = '{1000, 512};
    int          lat [2] = '{1, 2};
    bit          rdw [2] = '{1'b1, 1'b0};
    logic [15:0] clr [2] = '{16'hA5C3, 16'h0000};
    logic [15:0] mm [2][1024];
    int          cnt [2];
    logic [15:0] eq [2][2], pq [2][2];
    logic        ev [2][2], ee [2][2], pv [2][2], pe [2][2], ec [2];
    int tests = 0;
    int fails = 0;
    function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endfunction
    // memory is a plain array of words: B's bytes land first, then A's override the shared ones
    task automatic model(input int d);
        logic [15:0] old [2], nq [2], uq;
        logic        acc, uv, ue;
        logic        inr [2], wok [2], werr [2], nv [2], ne [2];
        if (rst) begin
            for (int i = 0; i < 1024; i++) mm[d][i] = clr[d];
            cnt[d] = dep[d];
            ec[d] = 1'b0;
            for (int p = 0; p < 2; p++) begin
                eq[d][p] = '0; ev[d][p] = 1'b0; ee[d][p] = 1'b0;
                pq[d][p] = '0; pv[d][p] = 1'b0; pe[d][p] = 1'b0;
            end
            return;
        end
        acc = cnt[d] == 0;
        if (cnt[d] > 0) cnt[d]--;
        for (int p = 0; p < 2; p++) begin
            inr[p]  = int'(ad[p]) < dep[d];
            old[p]  = mm[d][ad[p]];
            wok[p]  = acc && wr[p] && inr[p];
            werr[p] = acc && wr[p] && !inr[p];
        end
        ec[d] = wok[0] && wok[1] && ad[0] == ad[1];
        for (int p = 1; p >= 0; p--)
            if (wok[p])
                for (int i = 0; i < 2; i++)
                    if (be[p][i]) mm[d][ad[p]][8*i+:8] = dt[p][8*i+:8];
        for (int p = 0; p < 2; p++) begin
            nv[p] = acc && rd[p];
            ne[p] = nv[p] && !inr[p];
            nq[p] = !inr[p] ? 16'h0 : rdw[d] ? mm[d][ad[p]] : old[p];
            if (lat[d] == 2) begin
                uv = pv[d][p]; uq = pq[d][p]; ue = pe[d][p];
                pv[d][p] = nv[p]; pq[d][p] = nq[p]; pe[d][p] = ne[p];
            end else begin
                uv = nv[p]; uq = nq[p]; ue = ne[p];
            end
            ev[d][p] = uv;
            ee[d][p] = ue || werr[p];
            if (uv) eq[d][p] = uq;
        end
    endtask
    task automatic step();
        for (int d = 0; d < 2; d++) model(d);
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
                chk($sformatf("d%0d q_%s", d, p ? "b" : "a"), oq[d][p], eq[d][p]);
                chk($sformatf("d%0d valid_%s", d, p ? "b" : "a"), ov[d][p], ev[d][p]);
                chk($sformatf("d%0d err_%s", d, p ? "b" : "a"), oe[d][p], ee[d][p]);
            end
            chk($sformatf("d%0d busy", d), ob[d], cnt[d] > 0);
            chk($sformatf("d%0d collision", d), oc[d], ec[d]);
        end
    endtask
    task automatic idle();
        for (int p = 0; p < 2; p++) begin
            wr[p] = 1'b0; rd[p] = 1'b0; ad[p] = '0; dt[p] = '0; be[p] = '0;
        end
    endtask
    task automatic sweep();
        int n [2];
        n = '{0, 0};
        for (int k = 1; k <= 1100 && (n[0] == 0 || n[1] == 0); k++) begin
            step();
            for (int d = 0; d < 2; d++) if (n[d] == 0 && !ob[d]) n[d] = k;
            if (!ob[0] || !ob[1]) idle();
        end
        chk("busy length d0", n[0], 1000);
        chk("busy length d1", n[1], 512);
    endtask
    function automatic logic [9:0] raddr();
        case ($urandom_range(0, 3))
            0: return 10'($urandom_range(0, 7));
            1: return 10'($urandom_range(505, 520));
            2: return 10'($urandom_range(995, 1023));
            default: return 10'($urandom_range(0, 1023));
        endcase
    endfunction
    typedef struct {
        logic [3:0]  ctl;
        logic [9:0]  aa, ab;
        logic [15:0] da, db;
        logic [1:0]  ba, bb;
        logic [15:0] qa, qb;
        logic [4:0]  fl;
    } vec_t;
    vec_t tbl [15];
    initial begin
        // ctl = {wren_a, rden_a, wren_b, rden_b}; fl = {valid_a, valid_b, err_a, err_b, collision} of the 1000-word RDW=1 RAM
        tbl[0]  = '{4'b1000, 10'd10,   10'd0,    16'h0090, 16'h0000, 2'b11, 2'b00, 16'h0000, 16'h0000, 5'b00000};
        tbl[1]  = '{4'b0000, 10'd0,    10'd0,    16'h0000, 16'h0000, 2'b00, 2'b00, 16'h0000, 16'h0000, 5'b00000};
        tbl[2]  = '{4'b0001, 10'd0,    10'd10,   16'h0000, 16'h0000, 2'b00, 2'b00, 16'h0000, 16'h0090, 5'b01000};
        tbl[3]  = '{4'b1010, 10'd15,   10'd15,   16'h1111, 16'h2222, 2'b01, 2'b11, 16'h0000, 16'h0090, 5'b00001};
        tbl[4]  = '{4'b0100, 10'd15,   10'd0,    16'h0000, 16'h0000, 2'b00, 2'b00, 16'h2211, 16'h0090, 5'b10000};
        tbl[5]  = '{4'b1001, 10'd30,   10'd30,   16'hAAAA, 16'h0000, 2'b11, 2'b00, 16'h2211, 16'hAAAA, 5'b01000};
        tbl[6]  = '{4'b1000, 10'd512,  10'd0,    16'h0010, 16'h0000, 2'b11, 2'b00, 16'h2211, 16'hAAAA, 5'b00000};
        tbl[7]  = '{4'b1000, 10'd1000, 10'd0,    16'h0010, 16'h0000, 2'b11, 2'b00, 16'h2211, 16'hAAAA, 5'b00100};
        tbl[8]  = '{4'b0100, 10'd1000, 10'd0,    16'h0000, 16'h0000, 2'b00, 2'b00, 16'h0000, 16'hAAAA, 5'b10100};
        tbl[9]  = '{4'b0100, 10'd0,    10'd0,    16'h0000, 16'h0000, 2'b00, 2'b00, 16'hA5C3, 16'hAAAA, 5'b10000};
        tbl[10] = '{4'b1100, 10'd40,   10'd0,    16'h1234, 16'h0000, 2'b10, 2'b00, 16'h12C3, 16'hAAAA, 5'b10000};
        tbl[11] = '{4'b1010, 10'd51,   10'd50,   16'hCAFE, 16'hBEEF, 2'b11, 2'b01, 16'h12C3, 16'hAAAA, 5'b00000};
        tbl[12] = '{4'b0101, 10'd50,   10'd51,   16'h0000, 16'h0000, 2'b00, 2'b00, 16'hA5EF, 16'hCAFE, 5'b11000};
        tbl[13] = '{4'b0100, 10'd512,  10'd0,    16'h0000, 16'h0000, 2'b00, 2'b00, 16'h0010, 16'hCAFE, 5'b10000};
        tbl[14] = '{4'b1010, 10'd1000, 10'd1000, 16'h0001, 16'h0002, 2'b11, 2'b11, 16'h0010, 16'hCAFE, 5'b00110};
        idle();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        sweep();
        for (int i = 0; i < 15; i++) begin
            {wr[0], rd[0], wr[1], rd[1]} = tbl[i].ctl;
            ad[0] = tbl[i].aa; ad[1] = tbl[i].ab;
            dt[0] = tbl[i].da; dt[1] = tbl[i].db;
            be[0] = tbl[i].ba; be[1] = tbl[i].bb;
            step();
            chk($sformatf("tbl%0d q_a", i), oq[0][0], tbl[i].qa);
            chk($sformatf("tbl%0d q_b", i), oq[0][1], tbl[i].qb);
            chk($sformatf("tbl%0d flags", i), {ov[0][0], ov[0][1], oe[0][0], oe[0][1], oc[0]}, tbl[i].fl);
        end
        idle();
        for (int k = 0; k < 3000; k++) begin
            for (int p = 0; p < 2; p++) begin
                wr[p] = 1'($urandom_range(0, 1));
                rd[p] = 1'($urandom_range(0, 1));
                ad[p] = raddr();
                dt[p] = 16'($urandom);
                be[p] = 2'($urandom_range(0, 3));
            end
            step();
        end
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        wr[0] = 1'b1; ad[0] = 10'd3; dt[0] = 16'hFFFF; be[0] = 2'b11;
        repeat (200) step();
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        sweep();
        idle();
        rd[0] = 1'b1; ad[0] = 10'd3;
        step();
        chk("restart d0 addr3", {ov[0][0], oq[0][0]}, {1'b1, 16'hA5C3});
        idle();
        step();
        chk("restart d1 addr3", {ov[1][0], oq[1][0]}, {1'b1, 16'h0000});
        repeat (2) step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
